// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multi-port integer register file.
package rf_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned ZERO_REG  = 0;

  // Address width for a register count; at least one bit so ports stay legal.
  function automatic int unsigned rf_aw(input int unsigned nregs);
    return (nregs > 1) ? unsigned'($clog2(nregs)) : 1;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard; issue sets, writeback clears, set wins.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned AW    = rf_aw(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we0,
  input  logic [AW-1:0]    wa0,
  input  logic             we1,
  input  logic [AW-1:0]    wa1,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  output logic [NREGS-1:0] sb,
  output logic             any_busy
);

  logic [NREGS-1:0] sb_q;
  logic [NREGS-1:0] sb_nxt;

  // Clears first so a same-cycle issue to the same register overrides them.
  always_comb begin
    sb_nxt = sb_q;
    if (we0) sb_nxt[wa0] = 1'b0;
    if (we1) sb_nxt[wa1] = 1'b0;
    if (iss_en) sb_nxt[iss_addr] = 1'b1;
    sb_nxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_q <= '0;
    else        sb_q <= sb_nxt;
  end

  assign sb       = sb_q;
  assign any_busy = |sb_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port RV32 integer register file: NREAD read ports, two write ports,
// optional same-cycle write-to-read bypass and a pending-write scoreboard.
module register_file_mp
  import rf_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = rf_aw(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREAD*AW-1:0]   ra,
  output logic [NREAD*XLEN-1:0] rd,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [AW-1:0]         wa0,
  input  logic [AW-1:0]         wa1,
  input  logic [XLEN-1:0]       wd0,
  input  logic [XLEN-1:0]       wd1,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_addr,
  output logic                  any_busy
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] sb;
  logic             wr0_c;
  logic             wr1_c;
  logic             iss_c;
  logic [AW-1:0]    ra_a   [NREAD];
  logic [XLEN-1:0]  rd_v   [NREAD];
  logic             wr_hit [NREAD];

  assign wr0_c = we0 && (wa0 != AW'(ZERO_REG));
  assign wr1_c = we1 && (wa1 != AW'(ZERO_REG));
  assign iss_c = iss_en && (iss_addr != AW'(ZERO_REG));

  // Port 1 is applied last so it wins an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(NREGS); r++) regs[r] <= '0;
    end else begin
      if (wr0_c) regs[wa0] <= wd0;
      if (wr1_c) regs[wa1] <= wd1;
    end
  end

  rf_scoreboard #(.NREGS(NREGS), .AW(AW)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .we0      (wr0_c),
    .wa0      (wa0),
    .we1      (wr1_c),
    .wa1      (wa1),
    .iss_en   (iss_c),
    .iss_addr (iss_addr),
    .sb       (sb),
    .any_busy (any_busy)
  );

  // Read/bypass mux; reset also blanks bypassed data so outputs are 0 while held.
  always_comb begin
    rd      = '0;
    rd_busy = '0;
    for (int i = 0; i < int'(NREAD); i++) begin
      ra_a[i]   = ra[i*AW +: AW];
      rd_v[i]   = regs[ra_a[i]];
      wr_hit[i] = 1'b0;
      if (BYPASS != 0) begin
        if (wr0_c && (wa0 == ra_a[i])) begin
          rd_v[i]   = wd0;
          wr_hit[i] = 1'b1;
        end
        if (wr1_c && (wa1 == ra_a[i])) begin
          rd_v[i]   = wd1;
          wr_hit[i] = 1'b1;
        end
      end
      if ((ra_a[i] == AW'(ZERO_REG)) || !rst_n) begin
        rd_v[i]   = '0;
        wr_hit[i] = 1'b0;
      end
      rd[i*XLEN +: XLEN] = rd_v[i];
      rd_busy[i]         = sb[ra_a[i]] && !wr_hit[i] && (ra_a[i] != AW'(ZERO_REG));
    end
  end

endmodule
